// File: rtl/id_inst_buffer.sv
// id_inst_buffer: DEPTH-entry IF->ID {pc, inst} queue with branch flush and occupancy count.
// Define ID_IBUF_BYPASS_EN for a zero-latency combinational path when the queue is empty.
module id_inst_buffer #(
    parameter int DEPTH = 4,
    parameter int PC_W = 32,
    parameter int INST_W = 32,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [PC_W-1:0]   in_pc,
    input  logic [INST_W-1:0] in_inst,
    output logic              in_ready,
    output logic              out_valid,
    output logic [PC_W-1:0]   out_pc,
    output logic [INST_W-1:0] out_inst,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  count,
    output logic              full
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] MAX = CNT_W'(DEPTH);
    logic [PC_W-1:0] pc_mem [DEPTH];
    logic [INST_W-1:0] inst_mem [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic held, bypass, push, pop;
    assign held = count != '0;
`ifdef ID_IBUF_BYPASS_EN
    assign bypass = !held && in_valid && !flush;
`else
    assign bypass = 1'b0;
`endif
    assign full = count == MAX;
    assign in_ready = !full || out_ready;
    assign out_valid = held || bypass;
    assign out_pc = held ? pc_mem[rd_ptr] : bypass ? in_pc : '0;
    assign out_inst = held ? inst_mem[rd_ptr] : bypass ? in_inst : '0;
    // a bypassed entry taken by ID this cycle is never stored
    assign push = in_valid && in_ready && !(bypass && out_ready);
    assign pop = held && out_ready;
    always_ff @(posedge clk)
        if (push && !flush) begin
            pc_mem[wr_ptr] <= in_pc;
            inst_mem[wr_ptr] <= in_inst;
        end
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= (push && !pop) ? count + 1'b1 : (pop && !push) ? count - 1'b1 : count;
        end
endmodule

// File: tb/tb_id_inst_buffer.sv
// tb_id_inst_buffer: directed vector table plus hand sequences for id_inst_buffer (DEPTH=4).
module tb_id_inst_buffer;
    typedef struct {
        logic fl, iv, ordy;
        logic [31:0] pc, inst;
        logic [2:0] cnt;
        logic ov;
        logic [31:0] opc, oinst;
        logic irdy, full;
    } vec_t;
    localparam logic [31:0] A = 32'hBFC00000;
    logic clk = 1'b0;
    logic rst, flush, in_valid, out_ready;
    logic [31:0] in_pc, in_inst;
    logic in_ready, out_valid, full;
    logic [31:0] out_pc, out_inst;
    logic [2:0] count;
    int total = 0;
    int bad = 0;
    vec_t vq[$];
    vec_t v;
    logic eov;
    logic [31:0] eopc, eoinst;
    id_inst_buffer #(.DEPTH(4), .PC_W(32), .INST_W(32)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_pc(in_pc), .in_inst(in_inst), .in_ready(in_ready),
        .out_valid(out_valid), .out_pc(out_pc), .out_inst(out_inst), .out_ready(out_ready),
        .count(count), .full(full)
    );
    always #5 clk = ~clk;
    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask
    task automatic add(input int fl, input int iv, input logic [31:0] pc, input logic [31:0] inst,
                       input int ordy, input int cnt, input int ov, input logic [31:0] opc,
                       input logic [31:0] oinst, input int irdy, input int fu);
        vec_t t;
        t.fl = fl[0]; t.iv = iv[0]; t.pc = pc; t.inst = inst; t.ordy = ordy[0];
        t.cnt = 3'(cnt); t.ov = ov[0]; t.opc = opc; t.oinst = oinst;
        t.irdy = irdy[0]; t.full = fu[0];
        vq.push_back(t);
    endtask
    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_pc = '0; in_inst = '0;
        // fl iv pc inst ordy | cnt ov opc oinst irdy full (values seen before the edge)
        add(0, 1, A,          32'h3C010001, 0, 0, 0, 0,          0,            1, 0);
        add(0, 1, A + 32'h4,  32'h3C010002, 0, 1, 1, A,          32'h3C010001, 1, 0);
        add(0, 1, A + 32'h8,  32'h3C010003, 0, 2, 1, A,          32'h3C010001, 1, 0);
        add(0, 1, A + 32'hC,  32'h3C010004, 0, 3, 1, A,          32'h3C010001, 1, 0);
        add(0, 1, 32'hDEAD0000, 32'hDEADBEEF, 0, 4, 1, A,        32'h3C010001, 0, 1);
        add(0, 1, A + 32'h10, 32'h3C010005, 1, 4, 1, A,          32'h3C010001, 1, 1);
        add(0, 0, 0,          0,            1, 4, 1, A + 32'h4,  32'h3C010002, 1, 1);
        add(0, 0, 0,          0,            1, 3, 1, A + 32'h8,  32'h3C010003, 1, 0);
        add(0, 0, 0,          0,            1, 2, 1, A + 32'hC,  32'h3C010004, 1, 0);
        add(0, 0, 0,          0,            1, 1, 1, A + 32'h10, 32'h3C010005, 1, 0);
        add(0, 0, 0,          0,            1, 0, 0, 0,          0,            1, 0);
        add(0, 1, 32'h300,    32'h20000000, 0, 0, 0, 0,          0,            1, 0);
        add(0, 1, 32'h304,    32'h20000001, 0, 1, 1, 32'h300,    32'h20000000, 1, 0);
        add(0, 1, 32'h308,    32'h20000002, 0, 2, 1, 32'h300,    32'h20000000, 1, 0);
        add(1, 1, 32'h30C,    32'h20000003, 1, 3, 1, 32'h300,    32'h20000000, 1, 0);
        add(0, 0, 0,          0,            0, 0, 0, 0,          0,            1, 0);
        add(0, 1, 32'hBFC00100, 32'h24010100, 0, 0, 0, 0,        0,            1, 0);
        add(0, 0, 0,          0,            1, 1, 1, 32'hBFC00100, 32'h24010100, 1, 0);
        add(0, 0, 0,          0,            0, 0, 0, 0,          0,            1, 0);
        repeat (2) @(negedge clk);
        chk("rst count", count, 0);
        chk("rst out_valid", out_valid, 0);
        chk("rst full", full, 0);
        chk("rst in_ready", in_ready, 1);
        chk("rst out_pc", out_pc, 0);
        chk("rst out_inst", out_inst, 0);
        rst = 1'b0;
        foreach (vq[i]) begin
            v = vq[i];
            @(negedge clk);
            flush = v.fl; in_valid = v.iv; in_pc = v.pc; in_inst = v.inst; out_ready = v.ordy;
            #1;
            eov = v.ov; eopc = v.opc; eoinst = v.oinst;
`ifdef ID_IBUF_BYPASS_EN
            if (v.cnt == 0 && v.iv && !v.fl) begin
                eov = 1'b1; eopc = v.pc; eoinst = v.inst;
            end
`endif
            chk($sformatf("v%0d count", i), count, v.cnt);
            chk($sformatf("v%0d out_valid", i), out_valid, eov);
            chk($sformatf("v%0d out_pc", i), out_pc, eopc);
            chk($sformatf("v%0d out_inst", i), out_inst, eoinst);
            chk($sformatf("v%0d in_ready", i), in_ready, v.irdy);
            chk($sformatf("v%0d full", i), full, v.full);
        end
        // streaming push/pop of 10 entries wraps both pointers several times
        for (int i = 0; i <= 10; i++) begin
            @(negedge clk);
            flush = 1'b0; in_valid = i < 10; in_pc = 32'(32'h200 + 4 * i);
            in_inst = 32'(32'h100 + i); out_ready = i > 0;
            #1;
            if (i > 0) begin
                chk($sformatf("stream%0d out_valid", i), out_valid, 1);
                chk($sformatf("stream%0d out_pc", i), out_pc, 32'(32'h200 + 4 * (i - 1)));
                chk($sformatf("stream%0d count", i), count, 1);
            end
        end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b0;
        #1;
        chk("stream drained count", count, 0);
        chk("stream drained out_valid", out_valid, 0);
        // asynchronous reset between edges with two entries held
        @(negedge clk);
        in_valid = 1'b1; in_pc = 32'h500; in_inst = 32'h1;
        @(negedge clk);
        in_pc = 32'h504; in_inst = 32'h2;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        chk("pre-reset count", count, 2);
        #2 rst = 1'b1;
        #1;
        chk("async rst count", count, 0);
        chk("async rst out_valid", out_valid, 0);
        chk("async rst in_ready", in_ready, 1);
        @(negedge clk);
        rst = 1'b0;
        // empty queue with push and out_ready in the same cycle
        @(negedge clk);
        in_valid = 1'b1; in_pc = 32'h600; in_inst = 32'h24020005; out_ready = 1'b1;
        #1;
`ifdef ID_IBUF_BYPASS_EN
        chk("bypass out_valid", out_valid, 1);
        chk("bypass out_inst", out_inst, 32'h24020005);
        chk("bypass out_pc", out_pc, 32'h600);
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b0;
        #1;
        chk("bypass count", count, 0);
        chk("bypass after out_valid", out_valid, 0);
`else
        chk("nobypass out_valid", out_valid, 0);
        chk("nobypass out_inst", out_inst, 0);
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b0;
        #1;
        chk("nobypass count", count, 1);
        chk("nobypass next out_valid", out_valid, 1);
        chk("nobypass next out_inst", out_inst, 32'h24020005);
        @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        #1;
        chk("nobypass drained", count, 0);
`endif
        // flush on an empty queue hides the incoming entry and stores nothing
        @(negedge clk);
        flush = 1'b1; in_valid = 1'b1; in_pc = 32'h700; in_inst = 32'h7;
        #1;
        chk("flush empty out_valid", out_valid, 0);
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        #1;
        chk("flush empty count", count, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
